sar_conv_ctrl: RTL
==================

// Module: sar_conv_ctrl
// PURPOSE
//  Successive-approximation controller: the consumer side of the sample/hold front end.
//  - Drives the S/H 'sample' strobe.
//  - Presents binary-search trial codes to the DAC/residue path.
//  - Resolves one bit per clock from the comparator decision.
//  - Delivers an NBITS result with a one-cycle valid pulse.
//  Sits between the conversion-request logic and the analog S/H + comparator model.
// PARAMETERS
//  NBITS          10  result / DAC code width; midscale = 1<<(NBITS-1) (512 at default)
//  SAMPLE_CYCLES  4   clocks 'sample' is held high per conversion (min 1)
// PORTS
//  clk       in   1      conversion clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  start     in   1      conversion request, sampled in IDLE/DONE only
//  cmp       in   1      comparator: 1 = held input >= dac_code (combinational vs dac_code)
//  sample    out  1      S/H track strobe; falling edge = hold instant
//  dac_code  out  NBITS  current trial code to DAC/residue path
//  busy      out  1      high in SAMPLE, HOLD, CONV
//  dout      out  NBITS  last conversion result, stable between valid pulses
//  valid     out  1      one-cycle pulse, dout updated the same cycle
// BEHAVIOUR
//  Reset (async): state=IDLE; sample=0, dac_code=0, busy=0, dout=0, valid=0, mask=0.
//  All outputs are registered.
//  FSM: IDLE, SAMPLE, HOLD, CONV, DONE.
//  - IDLE:   start=1 -> SAMPLE. Otherwise stay.
//  - SAMPLE: sample=1 for exactly SAMPLE_CYCLES clocks (down-counter) -> HOLD.
//  - HOLD:   sample=0, one settle clock. On exit: mask=midscale, dac_code=midscale, result=0 -> CONV.
//  - CONV:   NBITS clocks. Each edge:
//      - result |= cmp ? mask : 0
//      - mask >>= 1
//      - dac_code = new result | new mask
//      - On the edge where mask==1, go to DONE.
//  - DONE:   valid=1, dout=final result (or the signed form, see CONFIGURATION), dac_code=0.
//      - start=1 -> SAMPLE (back-to-back); else -> IDLE.
//  Latency: start sampled at edge E0 -> valid high in the cycle after edge E(SAMPLE_CYCLES+NBITS+1).
//  - Default: 15 clocks after the start edge.
//  - Conversion period with start held high: SAMPLE_CYCLES+NBITS+2 = 16 clocks.
//  Boundaries:
//  - start during SAMPLE/HOLD/CONV: ignored, no queuing.
//  - start=1 in DONE: restarts directly; valid still pulses exactly once.
//  - cmp all ones -> dout = 2^NBITS-1. cmp all zeros -> dout = 0. No overflow/wrap is possible.
//  - rst mid-operation (any state): immediate IDLE with all reset values, including dout=0. The partial result is discarded.
//  - cmp is don't-care outside CONV.
// CONFIGURATION
//  SAR_DOUT_SIGNED_EN
//  - Defined: dout is two's complement about midscale (result with MSB inverted).
//    Example: code 512 -> 0; 1023 -> +511; 0 -> -512.
//  - Undefined: dout is straight offset binary (raw result).
//  Affects dout only. Internal result, dac_code and timing are identical in both builds.
// TESTING (comparator model cmp = (VIN >= dac_code), defaults)
//  1. Reset, pulse start with VIN=700.
//     -> sample high 4 clocks; dac_code sequence 512,768,640,704,672,688,696,700,702,701.
//     -> valid 15 clocks after start, dout=700 (signed build: 10'h0BC = +188).
//  2. VIN=0, then VIN=1023.
//     -> dout=0 / 1023 (signed build: 10'h200 / 10'h1FF). No wrap.
//  3. Pulse start again at CONV cycle 3.
//     -> ignored; exactly one valid; busy continuous from SAMPLE to CONV end.
//  4. Hold start high for 3 conversions with VIN=300,301,302.
//     -> valid every 16 clocks; dout=300,301,302; sample low for exactly 12 clocks between strobes.
//  5. Assert rst asynchronously mid-CONV (bit 5).
//     -> all outputs 0 immediately; next start yields a full, correct conversion.
//  6. start=0 after DONE.
//     -> FSM parks in IDLE; dout retains last value; valid stays 0.

Source files
------------

// File: rtl/sar_conv_ctrl.sv
// sar_conv_ctrl: SAR conversion controller (define SAR_DOUT_SIGNED_EN for two's-complement dout about midscale)
module sar_conv_ctrl #(
    parameter int NBITS         = 10,
    parameter int SAMPLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp,
    output logic             sample,
    output logic [NBITS-1:0] dac_code,
    output logic             busy,
    output logic [NBITS-1:0] dout,
    output logic             valid
);
    localparam int               CW       = $clog2(SAMPLE_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(SAMPLE_CYCLES - 1);
    localparam logic [NBITS-1:0] MID      = {1'b1, {(NBITS-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_SAMPLE, S_HOLD, S_CONV, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] mask_q, mask_d;
    logic [NBITS-1:0] result_q, result_d;
    logic [NBITS-1:0] dac_q, dac_d;
    logic [NBITS-1:0] dout_q, dout_d;
    logic             sample_q, sample_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [NBITS-1:0] res_next;
    logic [NBITS-1:0] dout_fmt;

    // result after folding in the current comparator decision
    assign res_next = result_q | (cmp ? mask_q : '0);

`ifdef SAR_DOUT_SIGNED_EN
    assign dout_fmt = {~res_next[NBITS-1], res_next[NBITS-2:0]};
`else
    assign dout_fmt = res_next;
`endif

    // next-state logic; outputs are derived from the next state so they register in step with it
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        result_d = result_q;
        dac_d    = dac_q;
        dout_d   = dout_q;
        case (state_q)
            S_IDLE: begin
                state_d = start ? S_SAMPLE : S_IDLE;
                cnt_d   = start ? CNT_LOAD : cnt_q;
            end
            S_SAMPLE: begin
                state_d = (cnt_q == '0) ? S_HOLD : S_SAMPLE;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
            end
            S_HOLD: begin
                state_d  = S_CONV;
                mask_d   = MID;
                dac_d    = MID;
                result_d = '0;
            end
            S_CONV: begin
                result_d = res_next;
                mask_d   = mask_q >> 1;
                dac_d    = mask_q[0] ? '0 : (res_next | (mask_q >> 1));
                state_d  = mask_q[0] ? S_DONE : S_CONV;
                dout_d   = mask_q[0] ? dout_fmt : dout_q;
            end
            S_DONE: begin
                state_d = start ? S_SAMPLE : S_IDLE;
                cnt_d   = start ? CNT_LOAD : cnt_q;
            end
            default: state_d = S_IDLE;
        endcase
        sample_d = (state_d == S_SAMPLE);
        busy_d   = (state_d == S_SAMPLE) || (state_d == S_HOLD) || (state_d == S_CONV);
        valid_d  = (state_d == S_DONE);
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            result_q <= '0;
            dac_q    <= '0;
            dout_q   <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            result_q <= result_d;
            dac_q    <= dac_d;
            dout_q   <= dout_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign sample   = sample_q;
    assign dac_code = dac_q;
    assign busy     = busy_q;
    assign dout     = dout_q;
    assign valid    = valid_q;
endmodule
